// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the control unit.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop and a flush that overrides push.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    count   = cnt_q;
    head    = mem_q[rd_q];
    do_pop  = pop && !empty;
    do_push = push && !full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response queue, redirect flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   q_count;
  logic [CW:0]     in_use;
  logic            q_full, q_empty, q_push, q_pop;
  logic            req_fire;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    push_entry, head_entry;

  always_comb begin
    in_use         = {1'b0, outstanding_q} + {1'b0, q_count};
    imem_req_valid = !rst && !redirect && (in_use < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Once draining is done every outstanding request is sequential from the
    // current stream, so the oldest one sits outstanding words behind fetch_pc.
    rsp_pc           = fetch_pc_q - XLEN'({outstanding_q, 2'b00});
    q_push           = imem_rsp_valid && (drop_q == '0) && !redirect;
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = rsp_pc;
    instr_valid      = !q_empty && !redirect;
    q_pop            = instr_valid && instr_ready;
    instr            = head_entry.instr;
    instr_pc         = head_entry.pc;
    instr_pc_plus4   = head_entry.pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else if (redirect) begin
      fetch_pc_q    <= redirect_pc & ~XLEN'(3);
      outstanding_q <= outstanding_q - CW'(imem_rsp_valid);
      drop_q        <= outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_q <= drop_q - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .flush     (redirect),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // The credit rule makes overflow impossible; firing here means it was broken.
  assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));

endmodule
